vending_ctrl_param: RTL
=======================

# vending_ctrl_param

Parametrised two-product vending controller, the next generation of the single-product credit FSM. It accumulates credit from two coin denominations and enforces a configurable credit ceiling, rejecting coins that would exceed it. It sells either of two products at per-product prices and returns change or refunds one unit per cycle. It sits behind the coin/button debouncers in the Tiny Tapeout user design and drives the dispense solenoids, the change hopper and the credit display.

## Interface
Parameters:
- CREDIT_W, 4, width of the credit register; MAX_CREDIT must be < 2**CREDIT_W.
- MAX_CREDIT, 12, highest credit value that may be held.
- COIN_HI_VAL, 2, unit value of the high-denomination coin; range 1..MAX_CREDIT.
- PRICE_A, 3, price of product A in units; range 1..MAX_CREDIT.
- PRICE_B, 5, price of product B in units; range 1..MAX_CREDIT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- coin_lo  in  1  1-unit coin inserted this cycle; single-cycle pulse from the debouncer.
- coin_hi  in  1  COIN_HI_VAL-unit coin inserted this cycle; single-cycle pulse.
- sel_a  in  1  request product A.
- sel_b  in  1  request product B.
- cancel  in  1  refund all credit.
- dispense_a  out  1  product A release; high for exactly 1 cycle.
- dispense_b  out  1  product B release; high for exactly 1 cycle.
- change_pulse  out  1  hopper releases 1 unit per high cycle.
- coin_reject  out  1  registered 1-cycle pulse: the coin(s) sampled on the previous edge were not credited.
- deny  out  1  registered 1-cycle pulse: the selection sampled on the previous edge was refused.
- busy  out  1  high in any state other than IDLE.
- credit  out  CREDIT_W  current credit register.

## Operation
States:
- IDLE
- DISP_A
- DISP_B
- PAYOUT

State-decoded outputs:
- dispense_a = (state==DISP_A).
- dispense_b = (state==DISP_B).
- change_pulse = (state==PAYOUT).
- busy = (state!=IDLE).

IDLE input priority per cycle, highest first:
1. cancel:
   - credit>0 → PAYOUT.
   - credit==0 → no effect.
   - Any coin sampled the same cycle is rejected.
   - Any selection sampled the same cycle is ignored; no deny.
2. Selection. Exactly one of sel_a/sel_b high:
   - credit ≥ price → credit -= price, go to DISP_x.
   - credit < price → deny, stay in IDLE.
   - Both high → deny, no state change.
   - Any coin sampled the same cycle as any selection is rejected.
3. Coins. sum = coin_lo·1 + coin_hi·COIN_HI_VAL:
   - credit+sum ≤ MAX_CREDIT → credit += sum.
   - Otherwise coin_reject and credit unchanged. This is all-or-nothing when both coins arrive together.
   - Compute credit+sum at CREDIT_W+1 bits; no wrap is possible.

Other state transitions:
- DISP_x (1 cycle) → PAYOUT if credit>0, else IDLE.
- PAYOUT: credit -= 1 each edge; when credit reaches 0 → IDLE. Payout time is therefore credit cycles.

Inputs while busy:
- Any coin → coin_reject.
- sel_a/sel_b/cancel are ignored; no deny.

Register behaviour:
- coin_reject and deny are flops, cleared every cycle unless set.
- An illegal state encoding → IDLE with credit unchanged.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, credit=0, all outputs 0. Applies mid-dispense or mid-payout; any remaining credit is lost.
- Release of rst_n is synchronised externally; the first active edge after release is a normal cycle.
- Coin accepted at edge N: credit updated at N.
- Selection at edge N: dispense_x high N..N+1, credit already shows the post-price value. First change_pulse N+1..N+2.
- deny/coin_reject: high during the cycle after the sampling edge.
- Inputs are level-sampled each edge. A sel held high re-triggers after return to IDLE; upstream supplies pulses.

## Test plan
- Reset/basic:
  - Stimulus: reset, then coin_lo ×3, then sel_a.
  - Required: credit 0→1→2→3; next cycle dispense_a=1 with credit=0; then IDLE; change_pulse never high.
- Change:
  - Stimulus: coin_hi ×3 (credit 6), then sel_b.
  - Required: dispense_b 1 cycle with credit=1; then change_pulse 1 cycle; credit=0, busy=0.
- Ceiling:
  - Stimulus: credit 11, coin_lo+coin_hi same cycle.
  - Required: coin_reject next cycle, credit stays 11. A following coin_lo is accepted → 12.
- Deny/invalid:
  - Stimulus: credit 4, sel_b.
  - Required: deny 1 cycle, credit 4.
  - Stimulus: sel_a+sel_b together.
  - Required: deny, no dispense.
- Cancel and busy:
  - Stimulus: credit 5, cancel with coin_lo same cycle.
  - Required: coin_reject; change_pulse exactly 5 cycles, credit counting 5..1. coin_hi/sel_a during payout → coin_reject only, no dispense.
- Async reset mid-payout:
  - Stimulus: assert rst_n=0 during the 2nd change_pulse cycle, between edges.
  - Required: all outputs 0 and credit=0 immediately without a clock edge; IDLE after release.

Source files
------------

// File: rtl/vending_ctrl_param.sv
// vending_ctrl_param: two-product vending controller.
// Accumulates credit from a 1-unit and a COIN_HI_VAL-unit coin up to a
// ceiling, sells product A or B at fixed prices, then pays change or a
// cancel refund out one unit per cycle through the hopper.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | accepting coins, selections and cancel
// DISP_A   | product A solenoid released (one cycle), price already taken
// DISP_B   | product B solenoid released (one cycle), price already taken
// PAYOUT   | one unit of change per cycle until credit reaches zero
module vending_ctrl_param #(
    parameter int CREDIT_W    = 4,
    parameter int MAX_CREDIT  = 12,
    parameter int COIN_HI_VAL = 2,
    parameter int PRICE_A     = 3,
    parameter int PRICE_B     = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_lo,
    input  logic                coin_hi,
    input  logic                sel_a,
    input  logic                sel_b,
    input  logic                cancel,
    output logic                dispense_a,
    output logic                dispense_b,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                deny,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DISP_A = 2'd1,
        S_DISP_B = 2'd2,
        S_PAYOUT = 2'd3
    } state_t;

    // Parameter values cast once to the widths they are compared against.
    // The coin sum is formed one bit wider than credit so the ceiling
    // check cannot wrap.
    localparam logic [CREDIT_W:0]   COIN_LO_W = (CREDIT_W+1)'(1);
    localparam logic [CREDIT_W:0]   COIN_HI_W = (CREDIT_W+1)'(COIN_HI_VAL);
    localparam logic [CREDIT_W:0]   MAX_W     = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_A_W = CREDIT_W'(PRICE_A);
    localparam logic [CREDIT_W-1:0] PRICE_B_W = CREDIT_W'(PRICE_B);
    localparam logic [CREDIT_W-1:0] ONE_W     = CREDIT_W'(1);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                coin_reject_q, coin_reject_d;
    logic                deny_q, deny_d;

    logic                any_coin;
    logic                any_sel;
    logic [CREDIT_W:0]   coin_sum;
    logic [CREDIT_W:0]   credit_plus;

    assign any_coin    = coin_lo | coin_hi;
    assign any_sel     = sel_a | sel_b;
    assign coin_sum    = (coin_lo ? COIN_LO_W : '0) + (coin_hi ? COIN_HI_W : '0);
    assign credit_plus = {1'b0, credit_q} + coin_sum;

    // State, credit and the two event flags; reset drops any held credit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            coin_reject_q <= 1'b0;
            deny_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            coin_reject_q <= coin_reject_d;
            deny_q        <= deny_d;
        end
    end

    // Next-state and credit update; in IDLE cancel beats a selection,
    // which beats coins, and any coin arriving alongside either is refused.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        coin_reject_d = 1'b0;
        deny_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cancel) begin
                    coin_reject_d = any_coin;
                    if (credit_q != '0) begin
                        state_d = S_PAYOUT;
                    end
                end else if (any_sel) begin
                    coin_reject_d = any_coin;
                    if (sel_a && sel_b) begin
                        deny_d = 1'b1;
                    end else if (sel_a) begin
                        if (credit_q >= PRICE_A_W) begin
                            credit_d = credit_q - PRICE_A_W;
                            state_d  = S_DISP_A;
                        end else begin
                            deny_d = 1'b1;
                        end
                    end else begin
                        if (credit_q >= PRICE_B_W) begin
                            credit_d = credit_q - PRICE_B_W;
                            state_d  = S_DISP_B;
                        end else begin
                            deny_d = 1'b1;
                        end
                    end
                end else if (any_coin) begin
                    // Both coins together are credited as a unit or not at all.
                    if (credit_plus <= MAX_W) begin
                        credit_d = credit_plus[CREDIT_W-1:0];
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end

            S_DISP_A, S_DISP_B: begin
                coin_reject_d = any_coin;
                state_d       = (credit_q != '0) ? S_PAYOUT : S_IDLE;
            end

            S_PAYOUT: begin
                coin_reject_d = any_coin;
                if (credit_q != '0) begin
                    credit_d = credit_q - ONE_W;
                end
                if (credit_q <= ONE_W) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode directly from registered state so reset clears them
    // without waiting for a clock edge.
    assign dispense_a   = (state_q == S_DISP_A);
    assign dispense_b   = (state_q == S_DISP_B);
    assign change_pulse = (state_q == S_PAYOUT);
    assign busy         = (state_q != S_IDLE);
    assign coin_reject  = coin_reject_q;
    assign deny         = deny_q;
    assign credit       = credit_q;

endmodule
